// File: rtl/afifo_read_checker.sv
// Read-side consumer for the AFIFO: checks that consecutive words increment by one and takes part
// in the toggle-based FIFO flush handshake with the writer/reset controller.
module afifo_read_checker #(
   parameter int unsigned W        = 16,
   parameter int unsigned CNT_W    = 32,
   parameter bit          STALL_EN = 1'b0
) (
   input  logic             clk_i,
   input  logic             rst_i,
   output logic             r_trigger_o,
   input  logic [W-1:0]     r_data_i,
   input  logic             r_ready_i,
   input  logic             rst_req_i,
   output logic             rst_ready_o,
   input  logic             rst_done_i,
   output logic             err_o,
   output logic [W-1:0]     err_expected_o,
   output logic [W-1:0]     err_actual_o,
   output logic [CNT_W-1:0] word_count_o
);

   typedef enum logic [1:0] {
      StRead     = 2'd0,
      StSignal   = 2'd1,
      StWaitDone = 2'd2,
      StHalt     = 2'd3
   } state_e;

   state_e           state_q, state_d;
   logic             trig_q, trig_d;
   logic             init_q, init_d;
   logic [W-1:0]     last_q, last_d;
   logic             err_q, err_d;
   logic [W-1:0]     err_exp_q, err_exp_d;
   logic [W-1:0]     err_act_q, err_act_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             rst_ready_q, rst_ready_d;
   logic [7:0]       lfsr_q, lfsr_d;

   // Two synchronizer stages followed by the edge-detect stage for each toggle input.
   logic req_s1_q, req_s2_q, req_s3_q;
   logic done_s1_q, done_s2_q, done_s3_q;
   logic req_p, done_p;

   logic         consume;
   logic [W-1:0] expected;

   assign req_p    = req_s2_q ^ req_s3_q;
   assign done_p   = done_s2_q ^ done_s3_q;
   assign consume  = trig_q & r_ready_i;
   assign expected = last_q + W'(1);

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         req_s1_q  <= 1'b0;
         req_s2_q  <= 1'b0;
         req_s3_q  <= 1'b0;
         done_s1_q <= 1'b0;
         done_s2_q <= 1'b0;
         done_s3_q <= 1'b0;
      end else begin
         req_s1_q  <= rst_req_i;
         req_s2_q  <= req_s1_q;
         req_s3_q  <= req_s2_q;
         done_s1_q <= rst_done_i;
         done_s2_q <= done_s1_q;
         done_s3_q <= done_s2_q;
      end
   end

   // x^8 + x^6 + x^5 + x^4 + 1, maximal length; free-running
   assign lfsr_d = {lfsr_q[6:0], lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3]};

   always_comb begin
      state_d     = state_q;
      trig_d      = trig_q;
      init_d      = init_q;
      last_d      = last_q;
      err_d       = err_q;
      err_exp_d   = err_exp_q;
      err_act_d   = err_act_q;
      cnt_d       = cnt_q;
      rst_ready_d = rst_ready_q;

      unique case (state_q)
         StRead: begin
            trig_d = STALL_EN ? lfsr_q[0] : 1'b1;
            if (consume) begin
               if (cnt_q != {CNT_W{1'b1}}) begin
                  cnt_d = cnt_q + CNT_W'(1);
               end
               if (!init_q) begin
                  last_d = r_data_i;
                  init_d = 1'b1;
               end else if (r_data_i == expected) begin
                  last_d = r_data_i;
               end else begin
                  err_d     = 1'b1;
                  err_exp_d = expected;
                  err_act_d = r_data_i;
                  trig_d    = 1'b0;
                  state_d   = StHalt;
               end
            end
         end
         StSignal: begin
            trig_d      = 1'b0;
            rst_ready_d = ~rst_ready_q;
            state_d     = StWaitDone;
         end
         StWaitDone: begin
            trig_d = 1'b0;
            if (done_p) begin
               init_d  = 1'b0;
               state_d = StRead;
            end
         end
         StHalt: begin
            trig_d = 1'b0;
         end
         default: begin
            trig_d  = 1'b0;
            state_d = StRead;
         end
      endcase

      // A flush request overrides everything except a halt, including one raised this cycle.
      if (req_p && (state_q != StHalt) && (state_d != StHalt)) begin
         trig_d  = 1'b0;
         state_d = StSignal;
      end
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_q     <= StRead;
         trig_q      <= 1'b0;
         init_q      <= 1'b0;
         last_q      <= '0;
         err_q       <= 1'b0;
         err_exp_q   <= '0;
         err_act_q   <= '0;
         cnt_q       <= '0;
         rst_ready_q <= 1'b0;
         lfsr_q      <= 8'h01;
      end else begin
         state_q     <= state_d;
         trig_q      <= trig_d;
         init_q      <= init_d;
         last_q      <= last_d;
         err_q       <= err_d;
         err_exp_q   <= err_exp_d;
         err_act_q   <= err_act_d;
         cnt_q       <= cnt_d;
         rst_ready_q <= rst_ready_d;
         lfsr_q      <= lfsr_d;
      end
   end

   assign r_trigger_o    = trig_q;
   assign rst_ready_o    = rst_ready_q;
   assign err_o          = err_q;
   assign err_expected_o = err_exp_q;
   assign err_actual_o   = err_act_q;
   assign word_count_o   = cnt_q;

endmodule

// File: tb/tb_afifo_read_checker.sv
// Directed bench for afifo_read_checker: stream, wrap, bad data, backpressure, flush, async reset.
module tb_afifo_read_checker;

   localparam int unsigned W     = 16;
   localparam int unsigned CNT_W = 32;

   logic             clk = 1'b0;
   logic             rst;
   logic             r_trigger;
   logic [W-1:0]     r_data;
   logic             r_ready;
   logic             rst_req;
   logic             rst_ready;
   logic             rst_done;
   logic             err;
   logic [W-1:0]     err_expected;
   logic [W-1:0]     err_actual;
   logic [CNT_W-1:0] word_count;

   int errors = 0;
   int checks = 0;

   afifo_read_checker #(
      .W        (W),
      .CNT_W    (CNT_W),
      .STALL_EN (1'b0)
   ) dut (
      .clk_i          (clk),
      .rst_i          (rst),
      .r_trigger_o    (r_trigger),
      .r_data_i       (r_data),
      .r_ready_i      (r_ready),
      .rst_req_i      (rst_req),
      .rst_ready_o    (rst_ready),
      .rst_done_i     (rst_done),
      .err_o          (err),
      .err_expected_o (err_expected),
      .err_actual_o   (err_actual),
      .word_count_o   (word_count)
   );

   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Leaves the DUT one cycle after release, r_trigger just asserted.
   task automatic do_reset();
      rst      = 1'b1;
      r_ready  = 1'b0;
      rst_req  = 1'b0;
      rst_done = 1'b0;
      step();
      step();
      rst = 1'b0;
      step();
   endtask

   task automatic feed(input logic [W-1:0] d);
      r_ready = 1'b1;
      r_data  = d;
      step();
      r_ready = 1'b0;
   endtask

   initial begin
      r_data = '0;
      rst    = 1'b1;
      r_ready  = 1'b0;
      rst_req  = 1'b0;
      rst_done = 1'b0;
      step();
      step();
      check("rst_trigger", 32'(r_trigger), 32'd0);
      check("rst_err", 32'(err), 32'd0);
      check("rst_count", word_count, 32'd0);
      check("rst_ready", 32'(rst_ready), 32'd0);
      check("rst_exp", 32'(err_expected), 32'd0);
      rst = 1'b0;
      step();
      check("trig_after_release", 32'(r_trigger), 32'd1);

      // Basic stream 0..9
      for (int i = 0; i < 10; i++) feed(W'(i));
      check("basic_count", word_count, 32'd10);
      check("basic_err", 32'(err), 32'd0);
      check("basic_trig", 32'(r_trigger), 32'd1);

      // Wrap through FFFF -> 0000
      do_reset();
      feed(16'hFFFE);
      feed(16'hFFFF);
      feed(16'h0000);
      feed(16'h0001);
      check("wrap_err", 32'(err), 32'd0);
      check("wrap_count", word_count, 32'd4);

      // Bad data
      do_reset();
      feed(16'h0005);
      feed(16'h0006);
      feed(16'h0008);
      check("bad_err", 32'(err), 32'd1);
      check("bad_expected", 32'(err_expected), 32'h0007);
      check("bad_actual", 32'(err_actual), 32'h0008);
      check("bad_trig", 32'(r_trigger), 32'd0);
      check("bad_count", word_count, 32'd3);
      r_ready = 1'b1;
      r_data  = 16'h0009;
      rst_req = 1'b1;
      for (int i = 0; i < 8; i++) step();
      r_ready = 1'b0;
      check("halt_no_ready", 32'(rst_ready), 32'd0);
      check("halt_trig", 32'(r_trigger), 32'd0);
      check("halt_count", word_count, 32'd3);
      check("halt_err_hold", 32'(err), 32'd1);
      check("halt_actual_hold", 32'(err_actual), 32'h0008);

      // Backpressure
      do_reset();
      r_data = 16'hDEAD;
      for (int i = 0; i < 20; i++) step();
      check("bp_idle_count", word_count, 32'd0);
      check("bp_idle_trig", 32'(r_trigger), 32'd1);
      feed(16'h0001);
      feed(16'h0002);
      check("bp_count", word_count, 32'd2);
      check("bp_err", 32'(err), 32'd0);

      // Flush handshake; consumes keep flowing until r_trigger drops
      do_reset();
      feed(16'h0010);
      rst_req = 1'b1;
      feed(16'h0011);
      feed(16'h0012);
      check("flush_trig_e2", 32'(r_trigger), 32'd1);
      feed(16'h0013);
      check("flush_trig_e3", 32'(r_trigger), 32'd0);
      check("flush_ready_e3", 32'(rst_ready), 32'd0);
      feed(16'h0014);
      check("flush_ready_e4", 32'(rst_ready), 32'd1);
      check("flush_count", word_count, 32'd4);
      for (int i = 0; i < 6; i++) step();
      check("flush_ready_once", 32'(rst_ready), 32'd1);
      check("flush_wait_trig", 32'(r_trigger), 32'd0);
      rst_done = 1'b1;
      step();
      step();
      step();
      check("done_trig_e3", 32'(r_trigger), 32'd0);
      step();
      check("done_trig_e4", 32'(r_trigger), 32'd1);
      feed(16'h0100);
      feed(16'h0101);
      check("post_flush_err", 32'(err), 32'd0);
      check("post_flush_count", word_count, 32'd6);

      // Async reset while waiting for rst_done
      rst_req = 1'b0;
      for (int i = 0; i < 6; i++) step();
      check("wait_ready_back", 32'(rst_ready), 32'd0);
      check("wait_trig", 32'(r_trigger), 32'd0);
      #3;
      rst      = 1'b1;
      rst_done = 1'b0;
      #1;
      check("async_trig", 32'(r_trigger), 32'd0);
      check("async_count", word_count, 32'd0);
      check("async_err", 32'(err), 32'd0);
      step();
      rst = 1'b0;
      step();
      check("async_release_trig", 32'(r_trigger), 32'd1);
      feed(16'h0500);
      feed(16'h0501);
      check("async_post_err", 32'(err), 32'd0);
      check("async_post_count", word_count, 32'd2);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
